// File: rtl/collision_scan_engine.sv
// Time-multiplexed player-vs-obstacle collision checker: snapshots a frame on start, then tests one obstacle per clock.
// Optional build macro: COLLISION_STICKY_EN (collision flag latches until rst).
module collision_scan_engine #(
  parameter int N_OBJ   = 3,
  parameter int COORD_W = 10,
  parameter int PX_OFF  = 14,
  parameter int PY_OFF  = 0,
  parameter int P_W     = 8,
  parameter int P_H     = 20,
  parameter int OBJ_W   = 32,
  parameter int OBJ_H   = 15,
  localparam int IDX_W  = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [COORD_W-1:0]         player_x,
  input  logic [COORD_W-1:0]         player_y,
  input  logic [N_OBJ*COORD_W-1:0]   obj_x,
  input  logic [N_OBJ*COORD_W-1:0]   obj_y,
  input  logic [N_OBJ-1:0]           obj_valid,
  output logic                       busy,
  output logic                       done,
  output logic [N_OBJ-1:0]           hit_mask,
  output logic [IDX_W-1:0]           first_idx,
  output logic                       collision
);

  localparam int EXT_W = COORD_W + 2;

  typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t                     state_r, state_s;
  logic                       capture_s, finish_s, last_s, obj_hit_s;
  logic [IDX_W-1:0]           idx_r;
  logic [COORD_W-1:0]         px_r, py_r, cur_ox_s, cur_oy_s;
  logic [N_OBJ*COORD_W-1:0]   ox_r, oy_r;
  logic [N_OBJ-1:0]           valid_r, work_mask_r, final_mask_s;
  logic                       busy_r, done_r, collision_r;
  logic [N_OBJ-1:0]           hit_mask_r;
  logic [IDX_W-1:0]           first_idx_r;

  // Sums are widened so boxes near the top of the coordinate range cannot wrap into a false result.
  function automatic logic box_hit(input logic [COORD_W-1:0] px, input logic [COORD_W-1:0] py,
                                   input logic [COORD_W-1:0] ox, input logic [COORD_W-1:0] oy);
    logic [EXT_W-1:0] p_l, p_r, p_t, p_b, o_l, o_r, o_t, o_b;
    p_l = EXT_W'(px) + EXT_W'(PX_OFF);
    p_r = p_l + EXT_W'(P_W);
    p_t = EXT_W'(py) + EXT_W'(PY_OFF);
    p_b = p_t + EXT_W'(P_H);
    o_l = EXT_W'(ox);
    o_r = o_l + EXT_W'(OBJ_W);
    o_t = EXT_W'(oy);
    o_b = o_t + EXT_W'(OBJ_H);
    box_hit = (o_r > p_l) && (o_l < p_r) && (o_b > p_t) && (o_t < p_b);
  endfunction

  function automatic logic [IDX_W-1:0] prio_enc(input logic [N_OBJ-1:0] m);
    prio_enc = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (m[i]) prio_enc = IDX_W'(i);
    end
  endfunction

  // Test the shadow obstacle selected by idx and fold it into the running mask.
  always_comb begin
    cur_ox_s     = ox_r[idx_r*COORD_W +: COORD_W];
    cur_oy_s     = oy_r[idx_r*COORD_W +: COORD_W];
    obj_hit_s    = valid_r[idx_r] & box_hit(px_r, py_r, cur_ox_s, cur_oy_s);
    last_s       = (idx_r == IDX_W'(N_OBJ - 1));
    if (obj_hit_s) begin
      final_mask_s = work_mask_r | (N_OBJ'(1'b1) << idx_r);
    end else begin
      final_mask_s = work_mask_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state and control strobes.
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    finish_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s   = SCAN;
          capture_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (last_s) begin
          state_s  = IDLE;
          finish_s = 1'b1;
        end else begin
          state_s = SCAN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Snapshot, scan index, working mask and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r       <= '0;
      px_r        <= '0;
      py_r        <= '0;
      ox_r        <= '0;
      oy_r        <= '0;
      valid_r     <= '0;
      work_mask_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      hit_mask_r  <= '0;
      first_idx_r <= '0;
      collision_r <= 1'b0;
    end else begin
      done_r <= finish_s;
      if (capture_s) begin
        px_r        <= player_x;
        py_r        <= player_y;
        ox_r        <= obj_x;
        oy_r        <= obj_y;
        valid_r     <= obj_valid;
        work_mask_r <= '0;
        idx_r       <= '0;
        busy_r      <= 1'b1;
      end else if (state_r == SCAN) begin
        work_mask_r <= final_mask_s;
        if (finish_s) begin
          idx_r       <= '0;
          busy_r      <= 1'b0;
          hit_mask_r  <= final_mask_s;
          first_idx_r <= prio_enc(final_mask_s);
`ifdef COLLISION_STICKY_EN
          collision_r <= collision_r | (|final_mask_s);
`else
          collision_r <= |final_mask_s;
`endif
        end else begin
          idx_r <= idx_r + IDX_W'(1);
        end
      end else begin
        busy_r <= 1'b0;
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign hit_mask  = hit_mask_r;
  assign first_idx = first_idx_r;
  assign collision = collision_r;

endmodule
